// File: rtl/parallel_in_serial_out_register_array_if.sv
// Load/unload bus for the parallel-in/serial-out register array.
// The master side is the producer plus downstream consumer; the slave side is the array.
interface parallel_in_serial_out_register_array_if #(
   parameter int unsigned BIT_WIDTH = 8,
   parameter int unsigned DEPTH     = 8
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic                       enable;
   logic                       load_valid;
   logic                       load_ready;
   logic [DEPTH*BIT_WIDTH-1:0] load_data;
   logic                       load_dir;
   logic [BIT_WIDTH-1:0]       out;
   logic                       out_valid;
   logic [CNT_W-1:0]           remaining;

   modport master (
      output enable,
      output load_valid,
      output load_data,
      output load_dir,
      input  load_ready,
      input  out,
      input  out_valid,
      input  remaining
   );

   modport slave (
      input  enable,
      input  load_valid,
      input  load_data,
      input  load_dir,
      output load_ready,
      output out,
      output out_valid,
      output remaining
   );
endinterface

// File: rtl/parallel_in_serial_out_register_array.sv
// Parallel-in/serial-out word array: captures DEPTH words per load and emits one
// word per enabled clock, head first, in the shift direction latched with the load.
module parallel_in_serial_out_register_array #(
   parameter int unsigned BIT_WIDTH = 8,
   parameter int unsigned DEPTH     = 8
) (
   input  logic clk,
   input  logic reset,
   parallel_in_serial_out_register_array_if.slave bus
);

   localparam int unsigned      CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   typedef enum logic {
      EMPTY    = 1'b0,
      SHIFTING = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [BIT_WIDTH-1:0] words_q [DEPTH];
   logic [BIT_WIDTH-1:0] words_d [DEPTH];
   logic [BIT_WIDTH-1:0] out_q, out_d;
   logic [CNT_W-1:0]     remaining_q, remaining_d;
   logic                 dir_q, dir_d;
   logic                 load_fire;
   logic                 shift_fire;
   logic                 last_word;

   // Ready when empty, or when the final word is being consumed this edge.
   assign bus.load_ready = (remaining_q == '0) || ((remaining_q == ONE) && bus.enable);
   assign load_fire      = bus.load_valid && bus.load_ready;
   assign shift_fire     = bus.enable && (state_q == SHIFTING) && !load_fire;
   assign last_word      = (remaining_q == ONE);

   assign bus.out       = out_q;
   assign bus.out_valid = (state_q == SHIFTING);
   assign bus.remaining = remaining_q;

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= EMPTY;
         out_q       <= '0;
         remaining_q <= '0;
         dir_q       <= 1'b0;
         for (int k = 0; k < DEPTH; k++) begin
            words_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         remaining_q <= remaining_d;
         dir_q       <= dir_d;
         for (int k = 0; k < DEPTH; k++) begin
            words_q[k] <= words_d[k];
         end
      end
   end

   // Next-state, counter and array update.
   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      remaining_d = remaining_q;
      dir_d       = dir_q;
      for (int k = 0; k < DEPTH; k++) begin
         words_d[k] = words_q[k];
      end

      case (state_q)
         EMPTY: begin
            if (load_fire) begin
               state_d = SHIFTING;
            end
         end
         SHIFTING: begin
            if (!load_fire && shift_fire && last_word) begin
               state_d = EMPTY;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase

      if (load_fire) begin
         // Words stay in natural order; the latched direction picks the head end.
         dir_d       = bus.load_dir;
         remaining_d = FULL;
         for (int k = 0; k < DEPTH; k++) begin
            words_d[k] = bus.load_data[k*BIT_WIDTH +: BIT_WIDTH];
         end
         out_d = bus.load_dir ? bus.load_data[(DEPTH-1)*BIT_WIDTH +: BIT_WIDTH]
                              : bus.load_data[BIT_WIDTH-1:0];
      end else if (shift_fire) begin
         remaining_d = remaining_q - ONE;
         if (dir_q) begin
            words_d[0] = '0;
            for (int k = 1; k < DEPTH; k++) begin
               words_d[k] = words_q[k-1];
            end
            out_d = words_q[DEPTH-2];
         end else begin
            words_d[DEPTH-1] = '0;
            for (int k = 0; k < DEPTH - 1; k++) begin
               words_d[k] = words_q[k+1];
            end
            out_d = words_q[1];
         end
         if (last_word) begin
            out_d = '0;
         end
      end
   end

   // Structural invariants of the counter and head register.
   a_remaining_range : assert property (@(posedge clk) disable iff (reset)
      remaining_q <= FULL);
   a_valid_tracks_count : assert property (@(posedge clk) disable iff (reset)
      (state_q == SHIFTING) == (remaining_q != '0));
   a_idle_out_zero : assert property (@(posedge clk) disable iff (reset)
      (state_q == EMPTY) |-> (out_q == '0));

endmodule

// File: tb/tb_parallel_in_serial_out_register_array.sv
// Directed self-checking bench for the parallel-in/serial-out register array.
module tb_parallel_in_serial_out_register_array;

   localparam int unsigned BW = 8;
   localparam int unsigned D  = 8;
   localparam logic [D*BW-1:0] DATA_A = 64'h33_05_99_2C_3B_0A_7E_6F;
   localparam logic [D*BW-1:0] DATA_B = 64'hA3_A4_A5_A6_A7_A8_A9_AA;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   logic [BW-1:0] exp_a [D];
   logic [BW-1:0] exp_b [D];

   parallel_in_serial_out_register_array_if #(.BIT_WIDTH(BW), .DEPTH(D)) bus ();

   parallel_in_serial_out_register_array #(.BIT_WIDTH(BW), .DEPTH(D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input logic [D*BW-1:0] data, input logic dir);
      bus.load_data  = data;
      bus.load_dir   = dir;
      bus.load_valid = 1'b1;
      bus.enable     = 1'b0;
      step();
      bus.load_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; bus.enable = 1'b0; bus.load_valid = 1'b0;
      bus.load_data = '0; bus.load_dir = 1'b0;
      step();
      reset = 1'b0;
      checks++; if (bus.out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h expected 00", bus.out); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
      checks++; if (bus.remaining !== 4'd0) begin errors++; $display("FAIL reset_remaining: got %0d expected 0", bus.remaining); end
      checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.load_ready); end
      bus.enable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if (bus.out !== 8'h00) begin errors++; $display("FAIL idle_out[%0d]: got %h expected 00", i, bus.out); end
         checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid[%0d]: got %b expected 0", i, bus.out_valid); end
         checks++; if (bus.remaining !== 4'd0) begin errors++; $display("FAIL idle_remaining[%0d]: got %0d expected 0", i, bus.remaining); end
         checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL idle_ready[%0d]: got %b expected 1", i, bus.load_ready); end
      end
      bus.enable = 1'b0;
   endtask

   task automatic test_right_shift();
      start_load(DATA_A, 1'b0);
      bus.enable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++; if (bus.out !== exp_a[i]) begin errors++; $display("FAIL right_out[%0d]: got %h expected %h", i, bus.out, exp_a[i]); end
         checks++; if (bus.remaining !== 4'(8 - i)) begin errors++; $display("FAIL right_remaining[%0d]: got %0d expected %0d", i, bus.remaining, 8 - i); end
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL right_valid[%0d]: got %b expected 1", i, bus.out_valid); end
         step();
      end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL right_end_valid: got %b expected 0", bus.out_valid); end
      checks++; if (bus.out !== 8'h00) begin errors++; $display("FAIL right_end_out: got %h expected 00", bus.out); end
      checks++; if (bus.remaining !== 4'd0) begin errors++; $display("FAIL right_end_remaining: got %0d expected 0", bus.remaining); end
      bus.enable = 1'b0;
   endtask

   task automatic test_left_shift();
      start_load(DATA_A, 1'b1);
      bus.enable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++; if (bus.out !== exp_a[7-i]) begin errors++; $display("FAIL left_out[%0d]: got %h expected %h", i, bus.out, exp_a[7-i]); end
         checks++; if (bus.remaining !== 4'(8 - i)) begin errors++; $display("FAIL left_remaining[%0d]: got %0d expected %0d", i, bus.remaining, 8 - i); end
         bus.load_dir = (i % 2 == 0);
         step();
      end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL left_end_valid: got %b expected 0", bus.out_valid); end
      checks++; if (bus.out !== 8'h00) begin errors++; $display("FAIL left_end_out: got %h expected 00", bus.out); end
      bus.enable = 1'b0;
      bus.load_dir = 1'b0;
   endtask

   task automatic test_stall();
      start_load(DATA_A, 1'b0);
      bus.enable = 1'b1;
      step();
      checks++; if (bus.out !== 8'h7E) begin errors++; $display("FAIL stall_first: got %h expected 7e", bus.out); end
      bus.enable = 1'b0;
      bus.load_data = DATA_B; bus.load_valid = 1'b1;
      checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b expected 0", bus.load_ready); end
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (bus.out !== 8'h7E) begin errors++; $display("FAIL stall_hold_out[%0d]: got %h expected 7e", i, bus.out); end
         checks++; if (bus.remaining !== 4'd7) begin errors++; $display("FAIL stall_hold_remaining[%0d]: got %0d expected 7", i, bus.remaining); end
      end
      bus.enable = 1'b1;
      checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_r7: got %b expected 0", bus.load_ready); end
      step();
      checks++; if (bus.out !== 8'h0A) begin errors++; $display("FAIL bp_out_r6: got %h expected 0a", bus.out); end
      checks++; if (bus.remaining !== 4'd6) begin errors++; $display("FAIL bp_remaining_r6: got %0d expected 6", bus.remaining); end
      checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_r6: got %b expected 0", bus.load_ready); end
      step();
      bus.load_valid = 1'b0;
      for (int i = 3; i < 8; i++) begin
         checks++; if (bus.out !== exp_a[i]) begin errors++; $display("FAIL bp_drain[%0d]: got %h expected %h", i, bus.out, exp_a[i]); end
         step();
      end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid: got %b expected 0", bus.out_valid); end
      bus.enable = 1'b0;
   endtask

   task automatic test_back_to_back();
      start_load(DATA_A, 1'b0);
      bus.enable = 1'b1;
      repeat (7) step();
      checks++; if (bus.out !== 8'h33) begin errors++; $display("FAIL b2b_last_out: got %h expected 33", bus.out); end
      checks++; if (bus.remaining !== 4'd1) begin errors++; $display("FAIL b2b_last_remaining: got %0d expected 1", bus.remaining); end
      bus.load_data = DATA_B; bus.load_dir = 1'b0; bus.load_valid = 1'b1;
      checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", bus.load_ready); end
      step();
      bus.load_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, bus.out_valid); end
         checks++; if (bus.out !== exp_b[i]) begin errors++; $display("FAIL b2b_out[%0d]: got %h expected %h", i, bus.out, exp_b[i]); end
         checks++; if (bus.remaining !== 4'(8 - i)) begin errors++; $display("FAIL b2b_remaining[%0d]: got %0d expected %0d", i, bus.remaining, 8 - i); end
         step();
      end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid: got %b expected 0", bus.out_valid); end
      bus.enable = 1'b0;
   endtask

   task automatic test_reset_mid();
      start_load(DATA_A, 1'b0);
      bus.enable = 1'b1;
      repeat (4) step();
      checks++; if (bus.out !== 8'h2C) begin errors++; $display("FAIL mid_pre_out: got %h expected 2c", bus.out); end
      checks++; if (bus.remaining !== 4'd4) begin errors++; $display("FAIL mid_pre_remaining: got %0d expected 4", bus.remaining); end
      reset = 1'b1; bus.load_data = DATA_B; bus.load_valid = 1'b1;
      step();
      reset = 1'b0; bus.load_valid = 1'b0;
      checks++; if (bus.out !== 8'h00) begin errors++; $display("FAIL mid_out: got %h expected 00", bus.out); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", bus.out_valid); end
      checks++; if (bus.remaining !== 4'd0) begin errors++; $display("FAIL mid_remaining: got %0d expected 0", bus.remaining); end
      checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", bus.load_ready); end
      for (int i = 0; i < 6; i++) begin
         step();
         checks++; if (bus.out !== 8'h00) begin errors++; $display("FAIL mid_after_out[%0d]: got %h expected 00", i, bus.out); end
         checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_after_valid[%0d]: got %b expected 0", i, bus.out_valid); end
      end
      start_load(DATA_B, 1'b1);
      checks++; if (bus.out !== 8'hA3) begin errors++; $display("FAIL mid_reload_out: got %h expected a3", bus.out); end
      checks++; if (bus.remaining !== 4'd8) begin errors++; $display("FAIL mid_reload_remaining: got %0d expected 8", bus.remaining); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      exp_a = '{8'h6F, 8'h7E, 8'h0A, 8'h3B, 8'h2C, 8'h99, 8'h05, 8'h33};
      exp_b = '{8'hAA, 8'hA9, 8'hA8, 8'hA7, 8'hA6, 8'hA5, 8'hA4, 8'hA3};
      test_reset();
      test_right_shift();
      test_left_shift();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
